mul_writeback: RTL and testbench
================================

Name: mul_writeback

Overview:
- Sequencer directly downstream of the multiply/multiply-accumulate executor.
- Accepts one 64-bit multiply result plus NZCV flags per transaction.
- Writes the result into the register file through the single shared write port: one beat for 32-bit MUL/MLA, two beats (RdLo then RdHi) for long multiplies.
- Issues a single CPSR flag update when the instruction's S bit is set.

Parameters:
- REG_AW, 4, register-file address width.
- DATA_W, 32, register width; the result input is 2*DATA_W.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  executor result valid
- in_ready  output  1  block can accept a result
- in_long  input  1  1 = long multiply (two writes), 0 = single write
- in_set_flags  input  1  S bit; update CPSR flags
- in_rd_lo  input  REG_AW  destination for result[DATA_W-1:0]
- in_rd_hi  input  REG_AW  destination for result[2*DATA_W-1:DATA_W]; ignored when in_long=0
- in_result  input  2*DATA_W  product/accumulate result
- in_nzcv  input  4  flags from executor {N,Z,C,V}
- flush  input  1  kill the in-flight transaction (pipeline flush/condition fail)
- rf_we  output  1  register-file write request
- rf_waddr  output  REG_AW  write address
- rf_wdata  output  DATA_W  write data
- rf_grant  input  1  write port granted this cycle; the write commits when rf_we & rf_grant
- flag_we  output  1  one-cycle CPSR flag write strobe
- flag_nzcv  output  4  flag value to write
- done  output  1  one-cycle pulse when a transaction retires

Behaviour:
- States: IDLE, WR_LO, WR_HI. Reset (rst=1 at a clk edge) forces IDLE from any state and discards captured data.
- Reset values: in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, flag_we=0, flag_nzcv=0, done=0.
- in_ready = (state==IDLE). No same-cycle accept while a transaction retires, so there is one bubble between transactions.
- Capture on in_valid & in_ready & ~flush:
  - Register long, set_flags, rd_lo, rd_hi, result, nzcv.
  - Next state WR_LO. The first write request appears the cycle after acceptance (latency 1).
- WR_LO:
  - rf_we = ~flush, rf_waddr = rd_lo, rf_wdata = result[DATA_W-1:0].
  - Hold all three outputs stable until rf_grant.
  - On grant: if long, go to WR_HI; else retire.
- WR_HI:
  - rf_we = ~flush, rf_waddr = rd_hi, rf_wdata = result[2*DATA_W-1:DATA_W].
  - Hold until rf_grant, then retire.
- Retire, on the cycle after the final granted write:
  - done=1 for one cycle.
  - flag_we=1 for one cycle if set_flags, with flag_nzcv = captured nzcv.
  - State returns to IDLE in the same cycle. Flags are therefore never written before all register writes commit.
- rf_grant while rf_we=0 is ignored. rf_grant is not required to stay asserted.
- Flush:
  - Any state with flush=1: rf_we is forced 0 combinationally; next state IDLE; no done, no flag_we.
  - A lo write granted in an earlier cycle is not undone.
  - Flush in IDLE blocks acceptance that cycle (in_ready stays 1; the input is dropped).
  - Flush in the retire cycle does not cancel that cycle's done/flag_we pulse.
- rd_lo == rd_hi (long): both writes issue in order, so the hi value ends in the register.
- rd_lo/rd_hi are not checked for r15; the register file handles PC writes.
- in_nzcv is forwarded unmodified; this block performs no flag arithmetic.
- in_valid while in_ready=0 is ignored; upstream holds the data.

Test Plan:
- Short write, grant tied 1: in_long=0, rd_lo=3, result=0x0000_0000_1234_5678, set_flags=0 -> cycle+1: rf_we=1, addr 3, data 0x12345678. Cycle+2: done=1, flag_we=0. Cycle+3: in_ready=1.
- Long write with flags: in_long=1, rd_lo=4, rd_hi=5, result=0xFFFF_FFFE_0000_0001, nzcv=4'b1000 -> writes r4=0x00000001, then r5=0xFFFFFFFE on consecutive cycles. Next cycle: flag_we=1, flag_nzcv=1000, done=1.
- Grant stall: long transaction, rf_grant low for 3 cycles in WR_LO and 2 in WR_HI -> addr/data held constant while stalled; exactly two committed writes; in_ready=0 throughout; flag_we only after the hi write is granted.
- Flush mid-long: lo write granted, then flush=1 in WR_HI -> rf_we=0 that cycle; state IDLE next; no done/flag_we; only r_lo written.
- Reset mid-operation: rst=1 in WR_HI with grant low -> next cycle all outputs at reset values, in_ready=1. A new short transaction then completes normally.
- Same-register long: rd_lo=rd_hi=7, result=0xAAAA_AAAA_5555_5555 -> write 0x55555555, then 0xAAAAAAAA to r7. Final r7=0xAAAAAAAA.

Source files
------------

// File: rtl/mul_writeback.sv
// mul_writeback: retires multiply results into the register file through the
// shared write port (one beat for MUL/MLA, two beats RdLo then RdHi for long
// multiplies) and then issues an optional CPSR flag update.
module mul_writeback #(
   parameter int REG_AW = 4,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_long,
   input  logic                in_set_flags,
   input  logic [REG_AW-1:0]   in_rd_lo,
   input  logic [REG_AW-1:0]   in_rd_hi,
   input  logic [2*DATA_W-1:0] in_result,
   input  logic [3:0]          in_nzcv,
   input  logic                flush,
   output logic                rf_we,
   output logic [REG_AW-1:0]   rf_waddr,
   output logic [DATA_W-1:0]   rf_wdata,
   input  logic                rf_grant,
   output logic                flag_we,
   output logic [3:0]          flag_nzcv,
   output logic                done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2
   } state_t;

   state_t              state_r;
   logic                ready_r;
   logic                we_r;
   logic [REG_AW-1:0]   waddr_r;
   logic [DATA_W-1:0]   wdata_r;
   logic                done_r;
   logic                flag_we_r;
   logic [3:0]          flag_nzcv_r;

   // Captured transaction fields still needed after the lo beat is presented.
   logic                long_r;
   logic                set_flags_r;
   logic [REG_AW-1:0]   rd_hi_r;
   logic [DATA_W-1:0]   result_hi_r;
   logic [3:0]          nzcv_r;

   // A flush kills the write request in the same cycle, so the strobe is the
   // only output with a combinational term.
   assign rf_we     = we_r & ~flush;
   assign in_ready  = ready_r;
   assign rf_waddr  = waddr_r;
   assign rf_wdata  = wdata_r;
   assign done      = done_r;
   assign flag_we   = flag_we_r;
   assign flag_nzcv = flag_nzcv_r;

   // Sequencer: capture, lo/hi write beats held until granted, retire pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         ready_r     <= 1'b1;
         we_r        <= 1'b0;
         waddr_r     <= {REG_AW{1'b0}};
         wdata_r     <= {DATA_W{1'b0}};
         done_r      <= 1'b0;
         flag_we_r   <= 1'b0;
         flag_nzcv_r <= 4'd0;
         long_r      <= 1'b0;
         set_flags_r <= 1'b0;
         rd_hi_r     <= {REG_AW{1'b0}};
         result_hi_r <= {DATA_W{1'b0}};
         nzcv_r      <= 4'd0;
      end else begin
         // Retire strobes are single-cycle pulses.
         done_r    <= 1'b0;
         flag_we_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (ready_r && in_valid && !flush) begin
                  // The lo beat is staged directly into the write port regs.
                  state_r     <= WR_LO;
                  ready_r     <= 1'b0;
                  we_r        <= 1'b1;
                  waddr_r     <= in_rd_lo;
                  wdata_r     <= in_result[DATA_W-1:0];
                  long_r      <= in_long;
                  set_flags_r <= in_set_flags;
                  rd_hi_r     <= in_rd_hi;
                  result_hi_r <= in_result[2*DATA_W-1:DATA_W];
                  nzcv_r      <= in_nzcv;
               end else begin
                  // Covers the retire bubble: ready again one cycle later.
                  ready_r <= 1'b1;
               end
            end
            WR_LO: begin
               if (flush) begin
                  state_r <= IDLE;
                  we_r    <= 1'b0;
                  ready_r <= 1'b1;
               end else if (rf_grant) begin
                  if (long_r) begin
                     state_r <= WR_HI;
                     waddr_r <= rd_hi_r;
                     wdata_r <= result_hi_r;
                  end else begin
                     state_r     <= IDLE;
                     we_r        <= 1'b0;
                     done_r      <= 1'b1;
                     flag_we_r   <= set_flags_r;
                     flag_nzcv_r <= set_flags_r ? nzcv_r : flag_nzcv_r;
                  end
               end else begin
                  state_r <= WR_LO;
               end
            end
            WR_HI: begin
               if (flush) begin
                  state_r <= IDLE;
                  we_r    <= 1'b0;
                  ready_r <= 1'b1;
               end else if (rf_grant) begin
                  state_r     <= IDLE;
                  we_r        <= 1'b0;
                  done_r      <= 1'b1;
                  flag_we_r   <= set_flags_r;
                  flag_nzcv_r <= set_flags_r ? nzcv_r : flag_nzcv_r;
               end else begin
                  state_r <= WR_HI;
               end
            end
            default: begin
               state_r <= IDLE;
               we_r    <= 1'b0;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_writeback.sv
// tb_mul_writeback: directed and randomized transactions checked against a
// transaction-level model (expected write list + register-file array).
module tb_mul_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_long;
   logic        in_set_flags;
   logic [3:0]  in_rd_lo;
   logic [3:0]  in_rd_hi;
   logic [63:0] in_result;
   logic [3:0]  in_nzcv;
   logic        flush;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        rf_grant;
   logic        flag_we;
   logic [3:0]  flag_nzcv;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] model_rf [16];
   logic [31:0] seen_rf  [16];

   always #5 clk = ~clk;

   mul_writeback #(.REG_AW(4), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_long(in_long), .in_set_flags(in_set_flags), .in_rd_lo(in_rd_lo),
      .in_rd_hi(in_rd_hi), .in_result(in_result), .in_nzcv(in_nzcv),
      .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rf_grant(rf_grant), .flag_we(flag_we), .flag_nzcv(flag_nzcv), .done(done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Observe one cycle: record real commits, then advance to posedge+1.
   task automatic tick();
      if (rf_we === 1'b1 && rf_grant === 1'b1) seen_rf[rf_waddr] = rf_wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic check_rf(input string tag);
      for (int r = 0; r < 16; r++) chk(tag, {32'd0, seen_rf[r]}, {32'd0, model_rf[r]});
   endtask

   task automatic check_reset_vals();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_flag_we", flag_we, 0);
      chk("rst_flag_nzcv", flag_nzcv, 0);
      chk("rst_done", done, 0);
   endtask

   // One transaction. stall_x < 0 means random grant; abort_beat selects the
   // beat (0 lo, 1 hi) in whose first cycle a flush or reset is applied.
   task automatic run_txn(input bit lng, input bit sf, input logic [3:0] lo,
                          input logic [3:0] hi, input logic [63:0] res,
                          input logic [3:0] nz, input int stall_lo,
                          input int stall_hi, input int abort_beat,
                          input bit abort_rst);
      logic [3:0]  exp_a [2];
      logic [31:0] exp_d [2];
      int nbeats, k, cyc, in_beat;
      bit aborted, abort_now, stall;
      exp_a[0] = lo;  exp_d[0] = res[31:0];
      exp_a[1] = hi;  exp_d[1] = res[63:32];
      nbeats = lng ? 2 : 1;

      in_valid = 1'b1; in_long = lng; in_set_flags = sf; in_rd_lo = lo;
      in_rd_hi = hi; in_result = res; in_nzcv = nz; flush = 1'b0; rf_grant = 1'b0;
      #1;
      chk("accept_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_result = {$urandom(), $urandom()};
      in_rd_lo = 4'($urandom()); in_rd_hi = 4'($urandom());

      k = 0; cyc = 0; in_beat = 0; aborted = 1'b0;
      while (k < nbeats && cyc < 200) begin
         abort_now = (k == abort_beat) && (in_beat == 0);
         if ((k == 0 ? stall_lo : stall_hi) < 0) stall = ($urandom_range(1) == 0);
         else stall = (in_beat < (k == 0 ? stall_lo : stall_hi));
         if (abort_now && abort_rst) begin
            rst = 1'b1; rf_grant = 1'b0;
         end else if (abort_now) begin
            flush = 1'b1; rf_grant = 1'($urandom());
         end else begin
            rf_grant = !stall;
         end
         #1;
         chk("busy_ready", in_ready, 0);
         chk("busy_done", done, 0);
         chk("busy_flag_we", flag_we, 0);
         if (abort_now && !abort_rst) begin
            chk("flush_kills_we", rf_we, 0);
         end else begin
            chk("wr_we", rf_we, 1);
            chk("wr_addr", rf_waddr, exp_a[k]);
            chk("wr_data", rf_wdata, exp_d[k]);
         end
         if (!abort_now && rf_grant) begin
            model_rf[exp_a[k]] = exp_d[k];
            k++;
            in_beat = 0;
         end else begin
            in_beat++;
         end
         tick();
         rst = 1'b0; flush = 1'b0; rf_grant = 1'b0;
         cyc++;
         if (abort_now) begin
            aborted = 1'b1;
            break;
         end
      end
      chk("no_timeout", (cyc < 200) ? 1 : 0, 1);

      if (aborted && abort_rst) begin
         check_reset_vals();
      end else if (aborted) begin
         chk("flush_ready", in_ready, 1);
         chk("flush_done", done, 0);
         chk("flush_flag_we", flag_we, 0);
         chk("flush_we", rf_we, 0);
      end else begin
         chk("retire_done", done, 1);
         chk("retire_flag_we", flag_we, sf);
         if (sf) chk("retire_nzcv", flag_nzcv, nz);
         chk("retire_ready", in_ready, 0);
         chk("retire_we", rf_we, 0);
         tick();
         chk("post_done", done, 0);
         chk("post_flag_we", flag_we, 0);
         chk("post_ready", in_ready, 1);
      end
      check_rf("regfile");
   endtask

   initial begin
      for (int r = 0; r < 16; r++) begin
         model_rf[r] = 32'd0;
         seen_rf[r]  = 32'd0;
      end
      rst = 1'b1; in_valid = 1'b0; in_long = 1'b0; in_set_flags = 1'b0;
      in_rd_lo = 4'd0; in_rd_hi = 4'd0; in_result = 64'd0; in_nzcv = 4'd0;
      flush = 1'b0; rf_grant = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_reset_vals();

      // Short write, grant always available.
      run_txn(1'b0, 1'b0, 4'd3, 4'd9, 64'h0000_0000_1234_5678, 4'b0000, 0, 0, -1, 1'b0);
      // Long write with flags.
      run_txn(1'b1, 1'b1, 4'd4, 4'd5, 64'hFFFF_FFFE_0000_0001, 4'b1000, 0, 0, -1, 1'b0);
      // Grant stall: 3 cycles in lo, 2 in hi.
      run_txn(1'b1, 1'b1, 4'd1, 4'd2, 64'hCAFE_F00D_DEAD_BEEF, 4'b0110, 3, 2, -1, 1'b0);
      // Flush in the hi beat after the lo write was granted.
      run_txn(1'b1, 1'b1, 4'd8, 4'd9, 64'h1111_2222_3333_4444, 4'b0101, 0, 0, 1, 1'b0);
      // Reset in the hi beat with grant low, then a normal short transaction.
      run_txn(1'b1, 1'b1, 4'd10, 4'd11, 64'h5555_6666_7777_8888, 4'b0011, 0, 0, 1, 1'b1);
      run_txn(1'b0, 1'b1, 4'd12, 4'd0, 64'h0000_0000_0BAD_F00D, 4'b0100, 1, 0, -1, 1'b0);
      // Same destination for both halves: hi value must win.
      run_txn(1'b1, 1'b0, 4'd7, 4'd7, 64'hAAAA_AAAA_5555_5555, 4'b0000, 0, 0, -1, 1'b0);
      chk("r7_final", seen_rf[7], 32'hAAAA_AAAA);

      // Flush in IDLE drops the offered input.
      in_valid = 1'b1; in_long = 1'b0; in_rd_lo = 4'd6; in_result = 64'h0000_0000_0000_0066;
      flush = 1'b1;
      #1;
      chk("idle_flush_ready", in_ready, 1);
      tick();
      in_valid = 1'b0; flush = 1'b0;
      chk("idle_flush_no_we", rf_we, 0);
      chk("idle_flush_ready_next", in_ready, 1);
      tick();
      chk("idle_flush_no_done", done, 0);

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         bit lng;
         int ab;
         lng = 1'($urandom());
         ab = ($urandom_range(9) == 0) ? int'($urandom_range(lng ? 1 : 0)) : -1;
         run_txn(lng, 1'($urandom()), 4'($urandom()), 4'($urandom()),
                 {$urandom(), $urandom()}, 4'($urandom()), -1, -1, ab, 1'b0);
         repeat ($urandom_range(2)) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
